agc_auto_loop: RTL

AGC_AUTO_LOOP -- requirements
Module: agc_auto_loop

---
 rtl/agc_auto_loop.sv | 338 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/agc_auto_loop.sv
// ---------------------------------------------------------------------------
// agc_auto_loop
//
// Automatic gain-control sequencer. Each iteration clears the per-channel
// power accumulators in the core, lets them integrate for a fixed window,
// waits for the pipeline to settle, then nudges every channel's scale one
// step towards a target power and applies the whole set at once.
//
// Sequence: IDLE -> TICK (1) -> MEASURE (WINDOW) -> SETTLE (SETTLE)
//           -> ADJUST (NCHAN, one channel per clock) -> APPLY (1)
//
// Optional feature (compile-time macro AGC_AUTO_CONVERGE_EN):
//   when defined, an iteration in which every channel is already inside the
//   deadband raises converged_o and parks the loop in IDLE until enable_i
//   rises again or init_i is pulsed. When undefined, converged_o is 0 and
//   the loop free-runs while enable_i is high.
//
// Ports:
//   clk_i        sole clock
//   rst_i        asynchronous, active-high reset
//   enable_i     run the loop while high (an iteration always completes)
//   init_i       reload all scales to SCALE_INIT (IDLE only)
//   target_i     target accumulator value
//   tol_i        deadband half-width around target_i
//   step_i       unsigned scale step per iteration
//   sq_accum_i   per-channel accumulators, channel n at [n*SQ_BITS +: SQ_BITS]
//   agc_tick_o   one-clock pulse clearing the core accumulators
//   agc_ce_o     accumulate enable for the measurement window
//   scale_o      per-channel scale registers, channel n at [n*SCALE_BITS +: SCALE_BITS]
//   scale_ce_o   one-hot strobe, bit k pulses once channel k holds its new scale
//   apply_o      one-clock pulse applying the loaded scales
//   busy_o       high in every state except IDLE
//   iter_o       completed iteration count (wraps)
//   converged_o  loop converged (see optional feature above)
//
// Parameter ranges: NCHAN >= 1, 1 <= WINDOW <= 2^24-1, 1 <= SETTLE,
// SCALE_BITS > 8.
// ---------------------------------------------------------------------------
module agc_auto_loop #(
  parameter int                    NCHAN      = 8,
  parameter int                    WINDOW     = 32768,
  parameter int                    SQ_BITS    = 25,
  parameter int                    SCALE_BITS = 17,
  parameter logic [SCALE_BITS-1:0] SCALE_INIT = 17'h04000,
  parameter int                    SETTLE     = 6
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          init_i,
  input  logic [SQ_BITS-1:0]            target_i,
  input  logic [SQ_BITS-1:0]            tol_i,
  input  logic [7:0]                    step_i,
  input  logic [NCHAN*SQ_BITS-1:0]      sq_accum_i,
  output logic                          agc_tick_o,
  output logic                          agc_ce_o,
  output logic [NCHAN*SCALE_BITS-1:0]   scale_o,
  output logic [NCHAN-1:0]              scale_ce_o,
  output logic                          apply_o,
  output logic                          busy_o,
  output logic [15:0]                   iter_o,
  output logic                          converged_o
);

`ifdef AGC_AUTO_CONVERGE_EN
  localparam logic CONV_EN = 1'b1;
`else
  localparam logic CONV_EN = 1'b0;
`endif

  localparam int CNT_W = 24;
  localparam int CH_W  = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  // Last count value of each timed state (counter restarts at 0 on entry).
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] ADJ_LAST = CNT_W'(NCHAN - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TICK    = 3'd1,
    ST_MEASURE = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_ADJUST  = 3'd4,
    ST_APPLY   = 3'd5
  } state_t;

  // Decrement with a floor at zero.
  function automatic logic [SCALE_BITS-1:0] sat_sub(
    input logic [SCALE_BITS-1:0] a,
    input logic [7:0]            b
  );
    logic [SCALE_BITS-1:0] b_ext;
    b_ext = {{(SCALE_BITS-8){1'b0}}, b};
    if (a < b_ext) begin
      sat_sub = {SCALE_BITS{1'b0}};
    end else begin
      sat_sub = a - b_ext;
    end
  endfunction

  // Increment with a ceiling at all-ones; one extra bit catches the carry.
  function automatic logic [SCALE_BITS-1:0] sat_add(
    input logic [SCALE_BITS-1:0] a,
    input logic [7:0]            b
  );
    logic [SCALE_BITS:0] sum;
    sum = {1'b0, a} + {{(SCALE_BITS-7){1'b0}}, b};
    if (sum[SCALE_BITS]) begin
      sat_add = {SCALE_BITS{1'b1}};
    end else begin
      sat_add = sum[SCALE_BITS-1:0];
    end
  endfunction

  state_t                 state_r;
  state_t                 next_state_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CH_W-1:0]        ch_s;
  logic                   start_s;
  logic                   enable_d_r;
  logic                   enable_rise_s;

  logic [SQ_BITS-1:0]     sq_sel_s;
  logic [SQ_BITS:0]       hi_s;
  logic [SQ_BITS-1:0]     lo_s;
  logic                   too_high_s;
  logic                   too_low_s;
  logic [SCALE_BITS-1:0]  cur_scale_s;
  logic [SCALE_BITS-1:0]  new_scale_s;
  logic [SCALE_BITS-1:0]  scale_r [NCHAN];
  logic                   all_ok_r;

  logic                   tick_s;
  logic                   ce_s;
  logic                   apply_s;
  logic                   busy_s;
  logic [NCHAN-1:0]       scale_ce_s;

  logic                   tick_r;
  logic                   ce_r;
  logic                   apply_r;
  logic                   busy_r;
  logic [NCHAN-1:0]       scale_ce_r;
  logic [15:0]            iter_r;
  logic                   converged_r;

  // During ADJUST the phase counter doubles as the channel index.
  assign ch_s          = cnt_r[CH_W-1:0];
  assign enable_rise_s = enable_i & ~enable_d_r;
  // A converged loop only restarts on a fresh enable edge or an init.
  assign start_s       = enable_i & (~converged_r | init_i | enable_rise_s);

  // State register and per-state phase counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 24'd0;
    end else begin
      state_r <= next_state_s;
      if ((next_state_s != state_r) || (state_r == ST_IDLE)) begin
        cnt_r <= 24'd0;
      end else begin
        cnt_r <= cnt_r + 24'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          next_state_s = ST_TICK;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_TICK: begin
        next_state_s = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (cnt_r == WIN_LAST) begin
          next_state_s = ST_SETTLE;
        end else begin
          next_state_s = ST_MEASURE;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == SET_LAST) begin
          next_state_s = ST_ADJUST;
        end else begin
          next_state_s = ST_SETTLE;
        end
      end
      ST_ADJUST: begin
        if (cnt_r == ADJ_LAST) begin
          next_state_s = ST_APPLY;
        end else begin
          next_state_s = ST_ADJUST;
        end
      end
      ST_APPLY: begin
        if (CONV_EN && all_ok_r) begin
          next_state_s = ST_IDLE;
        end else if (enable_i) begin
          next_state_s = ST_TICK;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered strobes line up
  // with the state they belong to.
  always_comb begin
    tick_s     = (next_state_s == ST_TICK);
    ce_s       = (next_state_s == ST_MEASURE);
    apply_s    = (next_state_s == ST_APPLY);
    busy_s     = (next_state_s != ST_IDLE);
    scale_ce_s = {NCHAN{1'b0}};
    if (state_r == ST_ADJUST) begin
      for (int i = 0; i < NCHAN; i++) begin
        scale_ce_s[i] = (ch_s == CH_W'(i));
      end
    end else begin
      scale_ce_s = {NCHAN{1'b0}};
    end
  end

  // Deadband compare and saturating step for the channel under evaluation.
  // hi carries one extra bit so target+tol never wraps; lo floors at zero.
  always_comb begin
    sq_sel_s    = {SQ_BITS{1'b0}};
    cur_scale_s = {SCALE_BITS{1'b0}};
    for (int i = 0; i < NCHAN; i++) begin
      if (ch_s == CH_W'(i)) begin
        sq_sel_s    = sq_accum_i[i*SQ_BITS +: SQ_BITS];
        cur_scale_s = scale_r[i];
      end else begin
        sq_sel_s    = sq_sel_s;
        cur_scale_s = cur_scale_s;
      end
    end
    hi_s = {1'b0, target_i} + {1'b0, tol_i};
    if (tol_i > target_i) begin
      lo_s = {SQ_BITS{1'b0}};
    end else begin
      lo_s = target_i - tol_i;
    end
    too_high_s = ({1'b0, sq_sel_s} > hi_s);
    too_low_s  = (sq_sel_s < lo_s);
    if (too_high_s) begin
      new_scale_s = sat_sub(cur_scale_s, step_i);
    end else if (too_low_s) begin
      new_scale_s = sat_add(cur_scale_s, step_i);
    end else begin
      new_scale_s = cur_scale_s;
    end
  end

  // Scale registers: reload on init in IDLE, update one channel per ADJUST clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCHAN; i++) begin
        scale_r[i] <= SCALE_INIT;
      end
    end else if ((state_r == ST_IDLE) && init_i) begin
      for (int i = 0; i < NCHAN; i++) begin
        scale_r[i] <= SCALE_INIT;
      end
    end else if (state_r == ST_ADJUST) begin
      for (int i = 0; i < NCHAN; i++) begin
        if (ch_s == CH_W'(i)) begin
          scale_r[i] <= new_scale_s;
        end
      end
    end
  end

  // Tracks whether every channel of this iteration stayed inside the deadband.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      all_ok_r <= 1'b0;
    end else if (state_r == ST_TICK) begin
      all_ok_r <= 1'b1;
    end else if ((state_r == ST_ADJUST) && (too_high_s || too_low_s)) begin
      all_ok_r <= 1'b0;
    end
  end

  // Registered strobes, status, iteration counter and convergence flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_r      <= 1'b0;
      ce_r        <= 1'b0;
      apply_r     <= 1'b0;
      busy_r      <= 1'b0;
      scale_ce_r  <= {NCHAN{1'b0}};
      iter_r      <= 16'd0;
      converged_r <= 1'b0;
      enable_d_r  <= 1'b0;
    end else begin
      tick_r     <= tick_s;
      ce_r       <= ce_s;
      apply_r    <= apply_s;
      busy_r     <= busy_s;
      scale_ce_r <= scale_ce_s;
      enable_d_r <= enable_i;
      if (state_r == ST_APPLY) begin
        iter_r <= iter_r + 16'd1;
      end
      if (CONV_EN && (state_r == ST_APPLY) && all_ok_r) begin
        converged_r <= 1'b1;
      end else if (init_i || enable_rise_s) begin
        converged_r <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_scale
    assign scale_o[g*SCALE_BITS +: SCALE_BITS] = scale_r[g];
  end

  assign agc_tick_o  = tick_r;
  assign agc_ce_o    = ce_r;
  assign apply_o     = apply_r;
  assign busy_o      = busy_r;
  assign scale_ce_o  = scale_ce_r;
  assign iter_o      = iter_r;
  assign converged_o = converged_r;

endmodule
